// File: rtl/uart_frame_tx.sv
// 8N1 UART transmitter that sends one 8-byte LED-control frame per accepted request:
// 55 A5 time[31:24] time[23:16] time[15:8] time[7:0] pattern F0, LSB first.
module uart_frame_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int BAUD_DIV = CLK_FREQ / BAUD
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        send,
  input  logic [31:0] time_val,
  input  logic [7:0]  pattern,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [2:0]       byte_idx;
  logic [31:0]      time_r;
  logic [7:0]       pattern_r;
  logic [7:0]       cur_byte;
  logic [2:0]       nxt_bit;
  logic             baud_wrap;

  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [31:0] t,
                                            input logic [7:0]  p);
    case (idx)
      3'd0:    frame_byte = 8'h55;
      3'd1:    frame_byte = 8'hA5;
      3'd2:    frame_byte = t[31:24];
      3'd3:    frame_byte = t[23:16];
      3'd4:    frame_byte = t[15:8];
      3'd5:    frame_byte = t[7:0];
      3'd6:    frame_byte = p;
      default: frame_byte = 8'hF0;
    endcase
  endfunction

  always_comb begin
    cur_byte  = frame_byte(byte_idx, time_r, pattern_r);
    nxt_bit   = bit_cnt + 3'd1;
    baud_wrap = (baud_cnt == BAUD_LAST);
  end

  // Captured fields are data only; they are never reset, just overwritten on acceptance.
  always_ff @(posedge Clk) begin
    if (state == S_IDLE && send && !Reset) begin
      time_r    <= time_val;
      pattern_r <= pattern;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      uart_tx  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != S_IDLE)
        baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          uart_tx <= 1'b1;
          busy    <= 1'b0;
          if (send) begin
            state    <= S_START;
            baud_cnt <= '0;
            byte_idx <= '0;
            uart_tx  <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_START: begin
          if (baud_wrap) begin
            state   <= S_DATA;
            bit_cnt <= '0;
            uart_tx <= cur_byte[0];
          end
        end
        S_DATA: begin
          if (baud_wrap) begin
            if (bit_cnt == 3'd7) begin
              state   <= S_STOP;
              uart_tx <= 1'b1;
            end else begin
              bit_cnt <= nxt_bit;
              uart_tx <= cur_byte[nxt_bit];
            end
          end
        end
        default: begin
          // Stop bit: chain straight into the next start bit, or close the frame.
          if (baud_wrap) begin
            if (byte_idx == 3'd7) begin
              state    <= S_IDLE;
              byte_idx <= '0;
              uart_tx  <= 1'b1;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              state    <= S_START;
              byte_idx <= byte_idx + 3'd1;
              uart_tx  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx: a frame-level reference model predicts the
// line, busy and done every cycle, and recorded traces are decoded against literal frames.
module tb_uart_frame_tx;
  localparam int BAUD     = 115200;
  localparam int CLK_FREQ = 1152000;
  localparam int B        = 10;
  localparam int FRAME    = 80 * B;
  localparam int NREC     = 32768;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        send;
  logic [31:0] time_val;
  logic [7:0]  pattern;
  logic        uart_tx, busy, done;

  always #5 Clk = ~Clk;

  uart_frame_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .Clk(Clk), .Reset(Reset), .send(send), .time_val(time_val), .pattern(pattern),
    .uart_tx(uart_tx), .busy(busy), .done(done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a frame becomes a queue of per-clock line levels.
  bit   exp_q[$];
  bit   fin      = 1'b0;
  bit   model_ok = 1'b0;
  logic exp_tx = 1'b1, exp_busy = 1'b0, exp_done = 1'b0;

  function automatic logic [63:0] frame_of(input logic [31:0] t, input logic [7:0] p);
    return {8'h55, 8'hA5, t, p, 8'hF0};
  endfunction

  task automatic push_frame(input logic [31:0] t, input logic [7:0] p);
    logic [63:0] f;
    logic [7:0]  by;
    f = frame_of(t, p);
    for (int k = 0; k < 8; k++) begin
      by = f[63 - 8*k -: 8];
      for (int c = 0; c < B; c++) exp_q.push_back(1'b0);
      for (int j = 0; j < 8; j++)
        for (int c = 0; c < B; c++) exp_q.push_back(by[j]);
      for (int c = 0; c < B; c++) exp_q.push_back(1'b1);
    end
  endtask

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (Reset) begin
      exp_q.delete();
      fin = 1'b0; model_ok = 1'b1;
      exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
    end else if (model_ok) begin
      if (exp_q.size() > 0) begin
        exp_tx = exp_q.pop_front(); exp_busy = 1'b1; exp_done = 1'b0;
        if (exp_q.size() == 0) fin = 1'b1;
      end else if (fin) begin
        fin = 1'b0; exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b1;
      end else if (send) begin
        push_frame(time_val, pattern);
        exp_tx = exp_q.pop_front(); exp_busy = 1'b1; exp_done = 1'b0;
      end else begin
        exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
      end
    end
  end

  // Per-cycle recording and comparison, away from the active edge.
  bit trx[NREC];
  bit bz[NREC];
  bit dn[NREC];

  always @(negedge Clk) begin
    if (cyc < NREC) begin
      trx[cyc] = uart_tx; bz[cyc] = busy; dn[cyc] = done;
    end
    if (model_ok)
      check("cycle_outputs", {61'd0, uart_tx, busy, done}, {61'd0, exp_tx, exp_busy, exp_done});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  function automatic int count_done(input int a, input int b);
    int n = 0;
    for (int c = a; c < b && c < NREC; c++) n += dn[c];
    return n;
  endfunction

  function automatic int count_busy(input int a, input int b);
    int n = 0;
    for (int c = a; c < b && c < NREC; c++) n += bz[c];
    return n;
  endfunction

  function automatic int count_low(input int a, input int b);
    int n = 0;
    for (int c = a; c < b && c < NREC; c++) n += (trx[c] == 1'b0);
    return n;
  endfunction

  function automatic int find_low(input int from, input int lim);
    for (int c = from; c < from + lim && c < NREC; c++)
      if (trx[c] == 1'b0) return c;
    return -1;
  endfunction

  function automatic int next_edge(input int from);
    for (int c = from + 1; c < NREC; c++)
      if (trx[c] != trx[c-1]) return c;
    return -1;
  endfunction

  // Mid-bit sampling decoder; a bad start or stop bit corrupts the result.
  function automatic logic [63:0] decode(input int s);
    logic [63:0] r = '0;
    logic [7:0]  by;
    if (s < 0) return 64'hDEAD_DEAD_DEAD_DEAD;
    for (int k = 0; k < 8; k++) begin
      if (trx[s + 10*k*B + B/2] != 1'b0 || trx[s + (10*k + 9)*B + B/2] != 1'b1)
        return 64'hBAD0_BAD0_BAD0_BAD0;
      for (int j = 0; j < 8; j++) by[j] = trx[s + (10*k + 1 + j)*B + B/2];
      r[63 - 8*k -: 8] = by;
    end
    return r;
  endfunction

  int s, s2, t0, e1, e2, e9, e10, tgt;
  logic [7:0]  p;
  logic [31:0] t;

  initial begin
    Reset = 1'b1; send = 1'b0; time_val = '0; pattern = '0;
    tick(5);
    check("reset_state", {61'd0, uart_tx, busy, done}, 64'd4);
    Reset = 1'b0;

    // Idle line after reset
    t0 = cyc;
    tick(1000);
    check("idle_low_cnt",  count_low(t0, cyc),  0);
    check("idle_busy_cnt", count_busy(t0, cyc), 0);
    check("idle_done_cnt", count_done(t0, cyc), 0);

    // Single frame, latency, busy width, done position, bit timing
    time_val = 32'h0000_01F4; pattern = 8'h9A; send = 1'b1;
    s = cyc + 1;
    tick(1);
    send = 1'b0;
    check("start_latency", {62'd0, uart_tx, busy}, 64'd1);
    tick(FRAME + 5);
    check("t2_frame", decode(s), 64'h55A5_0000_01F4_9AF0);
    check("t2_busy_width", count_busy(s - 1, s + FRAME + 3), FRAME);
    check("t2_done_at_fall", {61'd0, bz[s+FRAME-1], bz[s+FRAME], dn[s+FRAME]}, 64'd5);
    check("t2_done_cnt", count_done(s, s + FRAME + 5), 1);
    e1 = next_edge(s); e2 = next_edge(e1);
    check("t3_bit0_to_bit1", e2 - e1, B);
    e9 = s + 9*B; e10 = next_edge(e9);
    check("t3_stop_to_start", e10 - e9, B);
    check("t3_byte_len", e10 - s, 10*B);

    // send pulses while busy are ignored
    time_val = 32'h0000_01F4; pattern = 8'h9A; send = 1'b1;
    s = cyc + 1;
    tick(1);
    send = 1'b0;
    tick(3*B);
    time_val = 32'h1234_5678; pattern = 8'hF7; send = 1'b1;
    tick(1);
    send = 1'b0;
    tick(37*B);
    send = 1'b1;
    tick(2);
    send = 1'b0;
    tick(FRAME + 4*B);
    check("t4_frame", decode(s), 64'h55A5_0000_01F4_9AF0);
    check("t4_done_cnt", count_done(s, cyc), 1);
    check("t4_no_second", count_low(s + FRAME, cyc), 0);

    // send held high: two frames one idle clock apart
    p = 8'($urandom);
    time_val = 32'h9A78_5634; pattern = p; send = 1'b1;
    s = cyc + 1;
    tick(FRAME + 20*B);
    send = 1'b0;
    tick(FRAME);
    s2 = find_low(s + FRAME, 3*B);
    check("t5_frame1", decode(s), {16'h55A5, 32'h9A78_5634, p, 8'hF0});
    check("t5_frame2", decode(s2), {16'h55A5, 32'h9A78_5634, p, 8'hF0});
    check("t5_gap", s2 - (s + FRAME), 1);
    check("t5_done_cnt", count_done(s, cyc), 2);

    // Reset during byte 3, bit 4
    t = $urandom; p = 8'($urandom);
    time_val = t; pattern = p; send = 1'b1;
    s = cyc + 1;
    tick(1);
    send = 1'b0;
    tgt = s + 30*B + 5*B + B/2;
    tick(tgt - cyc);
    Reset = 1'b1; send = 1'b1;
    tick(1);
    Reset = 1'b0; send = 1'b0;
    check("t6_after_reset", {61'd0, uart_tx, busy, done}, 64'd4);
    t0 = cyc;
    tick(FRAME + B);
    check("t6_no_done", count_done(s, cyc), 0);
    check("t6_idle", count_low(t0, cyc), 0);
    t = $urandom; p = 8'($urandom);
    time_val = t; pattern = p; send = 1'b1;
    s = cyc + 1;
    tick(1);
    send = 1'b0;
    tick(FRAME + 3);
    check("t6_frame_after", decode(s), frame_of(t, p));

    // Randomized frames with stray requests while busy
    for (int i = 0; i < 4; i++) begin
      t = $urandom; p = 8'($urandom);
      time_val = t; pattern = p; send = 1'b1;
      s = cyc + 1;
      tick(1);
      send = 1'b0;
      tick($urandom_range(B, FRAME - 2*B));
      time_val = $urandom; pattern = 8'($urandom); send = 1'b1;
      tick(1);
      send = 1'b0;
      tick(FRAME + $urandom_range(2, 3*B));
      check("rand_frame", decode(s), frame_of(t, p));
      check("rand_done_cnt", count_done(s, cyc), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
